// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: result-source encoding,
// load funct3 codes and the control half of the M->W pipeline register.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Control fields of the M->W register; the WIDTH-sized datapath fields
    // live beside it in the top because a package type cannot take WIDTH.
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        result_src_e result_src;
        logic [2:0]  funct3;
    } wb_reg_t;

endpackage

// File: rtl/load_extend.sv
// Load-data lane extraction with sign/zero extension. Purely combinational;
// misalignment is not detected, the low offset bits are simply ignored.
module load_extend
    import wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]               word,
    input  logic [$clog2(WIDTH/8)-1:0]     offset,
    input  logic [2:0]                     funct3,
    output logic [WIDTH-1:0]               data
);

    localparam int OFF_W = $clog2(WIDTH/8);

    logic [OFF_W-1:0] half_off;
    logic [OFF_W-1:0] word_off;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      lane_w;

    // Clearing the low offset bits selects the naturally aligned lane.
    assign half_off = offset & ~OFF_W'(1);
    assign word_off = offset & ~OFF_W'(3);

    assign lane_b = word[{offset,   3'b000} +: 8];
    assign lane_h = word[{half_off, 3'b000} +: 16];
    assign lane_w = word[{word_off, 3'b000} +: 32];

    always_comb begin
        // NOTE: default assignment first so every path drives data -- no latch.
        data = WIDTH'($signed(lane_w));
        case (funct3)
            F3_LB:  data = WIDTH'($signed(lane_b));
            F3_LBU: data = WIDTH'(lane_b);
            F3_LH:  data = WIDTH'($signed(lane_h));
            F3_LHU: data = WIDTH'(lane_h);
            F3_LWU: if (WIDTH == 64) data = WIDTH'(lane_w);
            F3_LD:  if (WIDTH == 64) data = word;
            default: ;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: M->W pipeline register with stall/flush/valid, load
// extraction, result select, x0/bubble write gating and a retire counter.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_AW     = 5,
    parameter bit EN_INSTRET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallW,
    input  logic              FlushW,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        Funct3M,
    input  logic [WIDTH-1:0]  ALUResultM,
    input  logic [WIDTH-1:0]  ReadDataM,
    input  logic [WIDTH-1:0]  PCPlus4M,
    input  logic [WIDTH-1:0]  ImmExtM,
    input  logic [REG_AW-1:0] RdM,
    output logic              RegWriteW,
    output logic [REG_AW-1:0] RdW,
    output logic [WIDTH-1:0]  ResultW,
    output logic              ValidW,
    output logic [63:0]       instret_o
);

    localparam int OFF_W = $clog2(WIDTH/8);

    wb_reg_t           ctrl_q;
    logic [WIDTH-1:0]  alu_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [WIDTH-1:0]  pc4_q;
    logic [WIDTH-1:0]  imm_q;
    logic [REG_AW-1:0] rd_q;
    logic [WIDTH-1:0]  load_data;

    // NOTE: the datapath fields are reset too, so ResultW reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
        end else if (FlushW) begin
            // NOTE: non-blocking assignments for all sequential state.
            ctrl_q.valid     <= 1'b0;
            ctrl_q.reg_write <= 1'b0;
        end else if (!StallW) begin
            ctrl_q.valid      <= ValidM;
            ctrl_q.reg_write  <= RegWriteM;
            ctrl_q.result_src <= result_src_e'(ResultSrcM);
            ctrl_q.funct3     <= Funct3M;
            alu_q             <= ALUResultM;
            rdata_q           <= ReadDataM;
            pc4_q             <= PCPlus4M;
            imm_q             <= ImmExtM;
            rd_q              <= RdM;
        end
    end

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .word   (rdata_q),
        .offset (alu_q[OFF_W-1:0]),
        .funct3 (ctrl_q.funct3),
        .data   (load_data)
    );

    always_comb begin
        ResultW = alu_q;
        case (ctrl_q.result_src)
            RES_ALU:  ResultW = alu_q;
            RES_LOAD: ResultW = load_data;
            RES_PC4:  ResultW = pc4_q;
            RES_IMM:  ResultW = imm_q;
            default:  ResultW = alu_q;
        endcase
    end

    assign ValidW    = ctrl_q.valid;
    assign RdW       = rd_q;
    assign RegWriteW = ctrl_q.valid & ctrl_q.reg_write & (rd_q != '0);

    // An instruction retires when it leaves W: not stalled, or flushed out.
    if (EN_INSTRET) begin : g_instret
        logic [63:0] instret_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                instret_q <= '0;
            else if (ctrl_q.valid && (!StallW || FlushW))
                instret_q <= instret_q + 64'd1;
        end
        assign instret_o = instret_q;
    end else begin : g_no_instret
        assign instret_o = '0;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench: a 32-bit and a 64-bit writeback_unit share control
// inputs; table vectors plus hand sequences for stall, flush, reset, counter.
module tb_writeback_unit;
    import wb_pkg::*;

    logic        clk, rst_n, StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] alu32, rdata32, pc32, imm32;
    logic [63:0] alu64, rdata64, pc64, imm64;

    logic        rw32, v32, rw64, v64;
    logic [4:0]  rd32, rd64;
    logic [31:0] res32;
    logic [63:0] res64, cnt32, cnt64;

    writeback_unit #(.WIDTH(32), .REG_AW(5), .EN_INSTRET(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .ALUResultM(alu32), .ReadDataM(rdata32),
        .PCPlus4M(pc32), .ImmExtM(imm32), .RdM(RdM),
        .RegWriteW(rw32), .RdW(rd32), .ResultW(res32), .ValidW(v32),
        .instret_o(cnt32)
    );

    writeback_unit #(.WIDTH(64), .REG_AW(5), .EN_INSTRET(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .ALUResultM(alu64), .ReadDataM(rdata64),
        .PCPlus4M(pc64), .ImmExtM(imm64), .RdM(RdM),
        .RegWriteW(rw64), .RdW(rd64), .ResultW(res64), .ValidW(v64),
        .instret_o(cnt64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        bit          w64;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] alu, rdata, pc4, imm, exp_res;
        logic        exp_rw;
    } vec_t;

    typedef struct {
        string       name;
        bit          w64;
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] res;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input bit w, input logic [1:0] s,
                                input logic [2:0] f, input logic [4:0] rd, input logic rw,
                                input logic [63:0] alu, input logic [63:0] rdata,
                                input logic [63:0] pc4, input logic [63:0] imm,
                                input logic [63:0] res, input logic erw);
        vec_t v;
        v.name = n; v.w64 = w; v.src = s; v.f3 = f; v.rd = rd; v.rw = rw;
        v.alu = alu; v.rdata = rdata; v.pc4 = pc4; v.imm = imm;
        v.exp_res = res; v.exp_rw = erw;
        return v;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
            return;
        end
        e = sb.pop_front();
        if (e.w64) begin
            check({e.name, "/valid"}, {63'b0, v64},  {63'b0, e.valid});
            check({e.name, "/regw"},  {63'b0, rw64}, {63'b0, e.rw});
            check({e.name, "/rd"},    {59'b0, rd64}, {59'b0, e.rd});
            check({e.name, "/res"},   res64,         e.res);
        end else begin
            check({e.name, "/valid"}, {63'b0, v32},  {63'b0, e.valid});
            check({e.name, "/regw"},  {63'b0, rw32}, {63'b0, e.rw});
            check({e.name, "/rd"},    {59'b0, rd32}, {59'b0, e.rd});
            check({e.name, "/res"},   {32'b0, res32}, e.res);
        end
    endtask

    // Drive one M-stage slot, queue its expectation, compare after the edge.
    task automatic drive(input vec_t v, input logic valid);
        exp_t e;
        ValidM = valid; RegWriteM = v.rw; ResultSrcM = v.src; Funct3M = v.f3; RdM = v.rd;
        alu64 = v.alu;   alu32 = v.alu[31:0];
        rdata64 = v.rdata; rdata32 = v.rdata[31:0];
        pc64 = v.pc4;    pc32 = v.pc4[31:0];
        imm64 = v.imm;   imm32 = v.imm[31:0];
        e.name = v.name; e.w64 = v.w64; e.valid = valid; e.rw = v.exp_rw;
        e.rd = v.rd; e.res = v.exp_res;
        sb.push_back(e);
        @(posedge clk); #1;
        compare_out();
    endtask

    task automatic edge_then_check_empty(input string name, input logic [63:0] exp_cnt);
        @(posedge clk); #1;
        check({name, "/valid"}, {63'b0, v32},  64'd0);
        check({name, "/regw"},  {63'b0, rw32}, 64'd0);
        check({name, "/instret"}, cnt32, exp_cnt);
    endtask

    vec_t tbl[17];
    localparam logic [63:0] D64 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] D32 = 64'h0000_0000_8899_AABB;

    initial begin
        tbl[0]  = mk("d64_lw",   1, RES_LOAD, F3_LW,  10, 1, 64'h4, D64, 0, 0, 64'hFFFF_FFFF_8000_0000, 1);
        tbl[1]  = mk("d64_lwu",  1, RES_LOAD, F3_LWU, 10, 1, 64'h4, D64, 0, 0, 64'h0000_0000_8000_0000, 1);
        tbl[2]  = mk("d64_ld",   1, RES_LOAD, F3_LD,  11, 1, 64'h0, D64, 0, 0, D64, 1);
        tbl[3]  = mk("d64_lb",   1, RES_LOAD, F3_LB,  12, 1, 64'h0, D64, 0, 0, 64'h1, 1);
        tbl[4]  = mk("d64_lh6",  1, RES_LOAD, F3_LH,  13, 1, 64'h6, D64, 0, 0, 64'hFFFF_FFFF_FFFF_8000, 1);
        tbl[5]  = mk("lb1",      0, RES_LOAD, F3_LB,   3, 1, 64'h1, D32, 0, 0, 64'hFFFF_FFAA, 1);
        tbl[6]  = mk("lbu1",     0, RES_LOAD, F3_LBU,  3, 1, 64'h1, D32, 0, 0, 64'h0000_00AA, 1);
        tbl[7]  = mk("lh2",      0, RES_LOAD, F3_LH,   4, 1, 64'h2, D32, 0, 0, 64'hFFFF_8899, 1);
        tbl[8]  = mk("lhu2",     0, RES_LOAD, F3_LHU,  4, 1, 64'h2, D32, 0, 0, 64'h0000_8899, 1);
        tbl[9]  = mk("lw0",      0, RES_LOAD, F3_LW,   5, 1, 64'h0, D32, 0, 0, 64'h8899_AABB, 1);
        tbl[10] = mk("f3_011",   0, RES_LOAD, F3_LD,   5, 1, 64'h3, D32, 0, 0, 64'h8899_AABB, 1);
        tbl[11] = mk("lwu_at32", 0, RES_LOAD, F3_LWU,  5, 1, 64'h2, D32, 0, 0, 64'h8899_AABB, 1);
        tbl[12] = mk("pc4",      0, RES_PC4,  F3_LW,   1, 1, 64'h55, 0, 64'h104, 0, 64'h104, 1);
        tbl[13] = mk("imm",      0, RES_IMM,  F3_LW,   2, 1, 64'h55, 0, 0, 64'h1234_5000, 64'h1234_5000, 1);
        tbl[14] = mk("x0",       0, RES_ALU,  F3_LW,   0, 1, 64'hDEAD_BEEF, 0, 0, 0, 64'hDEAD_BEEF, 0);
        tbl[15] = mk("lb3",      0, RES_LOAD, F3_LB,   7, 0, 64'h3, D32, 0, 0, 64'hFFFF_FF88, 0);
        tbl[16] = mk("lbu0",     0, RES_LOAD, F3_LBU,  3, 1, 64'h0, D32, 0, 0, 64'h0000_00BB, 1);

        rst_n = 1'b0; StallW = 0; FlushW = 0; ValidM = 0; RegWriteM = 0;
        ResultSrcM = 0; Funct3M = 0; RdM = 0;
        alu32 = 0; rdata32 = 0; pc32 = 0; imm32 = 0;
        alu64 = 0; rdata64 = 0; pc64 = 0; imm64 = 0;
        #3;
        check("rst/valid",   {63'b0, v32},  64'd0);
        check("rst/regw",    {63'b0, rw32}, 64'd0);
        check("rst/rd",      {59'b0, rd32}, 64'd0);
        check("rst/res",     {32'b0, res32}, 64'd0);
        check("rst/instret", cnt32, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 17; i++) drive(tbl[i], 1'b1);
        // 17 back-to-back instructions: 16 have left W, the last sits in it.
        check("tbl/instret32", cnt32, 64'd16);
        check("tbl/instret64", cnt64, 64'd16);

        // Stall: W keeps lbu0 while M offers something different.
        StallW = 1; ValidM = 1; RegWriteM = 1; ResultSrcM = RES_ALU; RdM = 9;
        alu32 = 32'h1111; alu64 = 64'h1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d/res", i),     {32'b0, res32}, 64'hBB);
            check($sformatf("stall%0d/rd", i),      {59'b0, rd32},  64'd3);
            check($sformatf("stall%0d/regw", i),    {63'b0, rw32},  64'd1);
            check($sformatf("stall%0d/instret", i), cnt32,          64'd16);
        end

        StallW = 0; FlushW = 1;
        edge_then_check_empty("flush", 64'd17);
        FlushW = 0;

        drive(mk("after_flush", 0, RES_ALU, F3_LW, 5, 1, 64'h77, 0, 0, 0, 64'h77, 1), 1'b1);
        check("after_flush/instret", cnt32, 64'd17);
        StallW = 1; FlushW = 1;
        edge_then_check_empty("flush_stall", 64'd18);
        StallW = 0; FlushW = 0;

        // Asynchronous reset in the middle of a stall.
        drive(mk("pre_rst", 0, RES_ALU, F3_LW, 6, 1, 64'h99, 0, 0, 0, 64'h99, 1), 1'b1);
        StallW = 1;
        @(posedge clk); #1;
        check("pre_rst_hold/res",     {32'b0, res32}, 64'h99);
        check("pre_rst_hold/instret", cnt32, 64'd18);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/valid",   {63'b0, v32},  64'd0);
        check("midrst/regw",    {63'b0, rw32}, 64'd0);
        check("midrst/rd",      {59'b0, rd32}, 64'd0);
        check("midrst/res",     {32'b0, res32}, 64'd0);
        check("midrst/instret", cnt32, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; StallW = 0;

        // 12 slots, bubbles at 3 and 7, then one bubble to drain: 10 retire.
        for (int i = 0; i < 13; i++) begin
            logic vld;
            vld = (i != 3 && i != 7 && i != 12);
            drive(mk($sformatf("cnt%0d", i), 0, RES_ALU, F3_LW, 5'(i + 1), 1,
                     64'(256 + i), 0, 0, 0, 64'(256 + i), vld), vld);
        end
        check("cnt/instret", cnt32, 64'd10);

        // Counter wrap from all-ones.
        force dut32.g_instret.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut32.g_instret.instret_q;
        drive(mk("wrap_in", 0, RES_ALU, F3_LW, 8, 1, 64'hAB, 0, 0, 0, 64'hAB, 1), 1'b1);
        check("wrap/preload", cnt32, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(mk("wrap_out", 0, RES_ALU, F3_LW, 8, 1, 64'hCD, 0, 0, 0, 64'hCD, 0), 1'b0);
        check("wrap/instret", cnt32, 64'd0);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
